mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-port (CPU / IOP) arbiter in front of one fixed-latency memory.
// One memory cycle is in flight at a time. On contention the IOP wins unless it won last time.

module mem_port_arbiter_port (
    input  logic        clock,
    input  logic        reset,
    input  logic        ack_set_i,
    input  logic        done_set_i,
    input  logic        cap_i,
    input  logic [31:0] mem_rdata_i,
    output logic        ack_o,
    output logic        done_o,
    output logic [31:0] rdata_o
);
    logic        ack_q;
    logic        done_q;
    logic [31:0] rdata_q, rdata_d;

    // Read data stays put until this port's next read completes.
    always_comb begin
        rdata_d = rdata_q;
        if (cap_i) rdata_d = mem_rdata_i;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ack_q   <= 1'b0;
            done_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            ack_q   <= ack_set_i;
            done_q  <= done_set_i;
            rdata_q <= rdata_d;
        end
    end

    assign ack_o   = ack_q;
    assign done_o  = done_q;
    assign rdata_o = rdata_q;
endmodule

module mem_port_arbiter #(
    parameter int MEM_LAT = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [16:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_ack,
    output logic        cpu_done,
    output logic [31:0] cpu_rdata,
    input  logic        iop_req,
    input  logic        iop_we,
    input  logic [16:0] iop_addr,
    input  logic [31:0] iop_wdata,
    output logic        iop_ack,
    output logic        iop_done,
    output logic [31:0] iop_rdata,
    output logic        mem_start,
    output logic        mem_we,
    output logic [16:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);
    localparam int         NUM_PORTS = 2;
    localparam logic [3:0] LAT       = 4'(MEM_LAT);
    localparam logic       OWN_CPU   = 1'b0;
    localparam logic       OWN_IOP   = 1'b1;

    typedef enum logic {IDLE, BUSY} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        owner_q, owner_d;
    logic        last_q, last_d;
    logic        start_q, start_d;
    logic        we_q, we_d;
    logic [16:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        winner;

    logic [NUM_PORTS-1:0]       port_req, port_we;
    logic [NUM_PORTS-1:0][16:0] port_addr;
    logic [NUM_PORTS-1:0][31:0] port_wdata, port_rdata;
    logic [NUM_PORTS-1:0]       ack_set, done_set, cap;
    logic [NUM_PORTS-1:0]       port_ack, port_done;

    assign port_req   = {iop_req, cpu_req};
    assign port_we    = {iop_we, cpu_we};
    assign port_addr  = {iop_addr, cpu_addr};
    assign port_wdata = {iop_wdata, cpu_wdata};

    // Alternate on contention: the IOP yields only if it holds the last grant.
    always_comb begin
        winner = OWN_CPU;
        if (port_req[OWN_IOP] && (!port_req[OWN_CPU] || last_q != OWN_IOP)) winner = OWN_IOP;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        owner_d  = owner_q;
        last_d   = last_q;
        start_d  = 1'b0;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        ack_set  = '0;
        done_set = '0;
        cap      = '0;
        case (state_q)
            IDLE: begin
                if (|port_req) begin
                    state_d         = BUSY;
                    cnt_d           = LAT;
                    owner_d         = winner;
                    last_d          = winner;
                    start_d         = 1'b1;
                    we_d            = port_we[winner];
                    addr_d          = port_addr[winner];
                    wdata_d         = port_wdata[winner];
                    ack_set[winner] = 1'b1;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 4'd1;
                // Last busy cycle: mem_rdata is valid now, done shows next cycle.
                if (cnt_q == 4'd1) begin
                    state_d           = IDLE;
                    done_set[owner_q] = 1'b1;
                    cap[owner_q]      = !we_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            owner_q <= OWN_CPU;
            last_q  <= OWN_CPU;
            start_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            start_q <= start_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        mem_port_arbiter_port u_port (
            .clock      (clock),
            .reset      (reset),
            .ack_set_i  (ack_set[p]),
            .done_set_i (done_set[p]),
            .cap_i      (cap[p]),
            .mem_rdata_i(mem_rdata),
            .ack_o      (port_ack[p]),
            .done_o     (port_done[p]),
            .rdata_o    (port_rdata[p])
        );
    end

    assign cpu_ack   = port_ack[OWN_CPU];
    assign cpu_done  = port_done[OWN_CPU];
    assign cpu_rdata = port_rdata[OWN_CPU];
    assign iop_ack   = port_ack[OWN_IOP];
    assign iop_done  = port_done[OWN_IOP];
    assign iop_rdata = port_rdata[OWN_IOP];
    assign mem_start = start_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter. Two instances (MEM_LAT=3 and MEM_LAT=1) receive
// independent random and directed traffic. The model predicts each grant from timing arithmetic.

module tb_mem_port_arbiter;
    typedef struct packed {
        int          ack_cyc;
        int          done_cyc;
        logic [31:0] rdata;
        logic [31:0] wdata;
        logic [16:0] addr;
        logic        we;
        logic        port;
    } txn_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // Index [k][p]: k=0 is the MEM_LAT=3 instance, k=1 is the MEM_LAT=1 instance; p=0 CPU, p=1 IOP.
    logic [1:0][1:0]       req, we, ack, done;
    logic [1:0][1:0][16:0] addr;
    logic [1:0][1:0][31:0] wdata, rdata;
    logic [1:0]            mstart, mwe;
    logic [1:0][16:0]      maddr;
    logic [1:0][31:0]      mwdata, mrdata;

    for (genvar k = 0; k < 2; k++) begin : g_dut
        mem_port_arbiter #(.MEM_LAT(k == 0 ? 3 : 1)) u_dut (
            .clock(clk), .reset(rst),
            .cpu_req(req[k][0]), .cpu_we(we[k][0]), .cpu_addr(addr[k][0]), .cpu_wdata(wdata[k][0]),
            .cpu_ack(ack[k][0]), .cpu_done(done[k][0]), .cpu_rdata(rdata[k][0]),
            .iop_req(req[k][1]), .iop_we(we[k][1]), .iop_addr(addr[k][1]), .iop_wdata(wdata[k][1]),
            .iop_ack(ack[k][1]), .iop_done(done[k][1]), .iop_rdata(rdata[k][1]),
            .mem_start(mstart[k]), .mem_we(mwe[k]), .mem_addr(maddr[k]), .mem_wdata(mwdata[k]),
            .mem_rdata(mrdata[k])
        );
    end

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    int          free_at [2];
    bit          last_iop[2];
    int          cap_cyc [2];
    logic [31:0] cap_data[2];
    bit          dir_v   [2];
    logic [31:0] dir_d   [2];
    txn_t        exq     [2][$];
    txn_t        cur     [2];
    bit          cur_v   [2];
    logic [31:0] exp_rd  [2][2];
    int          alog_c[$];
    int          alog_p[$];

    function automatic int lat(int k);
        return (k == 0) ? 3 : 1;
    endfunction

    task automatic check(string nm, int k, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s inst%0d cyc=%0d got=%0h exp=%0h", nm, k, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            free_at[k]  = 0;
            last_iop[k] = 1'b0;
            cap_cyc[k]  = -1;
            exq[k].delete();
            cur_v[k]    = 1'b0;
            exp_rd[k][0] = '0;
            exp_rd[k][1] = '0;
        end
    endtask

    always @(posedge rst) model_reset();

    // Reference model: one transaction occupies [ack, ack+LAT] and the arbiter may grant again
    // on the edge that ends the done cycle.
    always @(posedge clk) begin
        if (rst) model_reset();
        else begin
            for (int k = 0; k < 2; k++) begin
                if (cyc >= free_at[k] && (req[k][0] || req[k][1])) begin
                    int   w;
                    txn_t t;
                    if (req[k][0] && req[k][1]) w = last_iop[k] ? 0 : 1;
                    else                        w = req[k][1] ? 1 : 0;
                    t.port     = (w == 1);
                    t.we       = we[k][w];
                    t.addr     = addr[k][w];
                    t.wdata    = wdata[k][w];
                    t.rdata    = dir_v[k] ? dir_d[k] : $urandom;
                    dir_v[k]   = 1'b0;
                    t.ack_cyc  = cyc + 1;
                    t.done_cyc = cyc + 1 + lat(k);
                    exq[k].push_back(t);
                    free_at[k]  = cyc + 1 + lat(k);
                    last_iop[k] = (w == 1);
                    cap_cyc[k]  = cyc + lat(k);
                    cap_data[k] = t.rdata;
                end
            end
        end
        cyc++;
    end

    // Memory: correct data only in the single capture cycle, noise otherwise.
    initial begin
        mrdata = '0;
        forever begin
            @(posedge clk); #1;
            for (int k = 0; k < 2; k++) mrdata[k] = (cyc == cap_cyc[k]) ? cap_data[k] : $urandom;
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            bit   ea, ed;
            txn_t h;
            if (rst) begin
                check("reset_outputs_zero", k, 32'((|ack[k]) | (|done[k]) | mstart[k] | mwe[k] |
                      (|maddr[k]) | (|mwdata[k]) | (|rdata[k])), 32'd0);
            end else begin
                h  = '0;
                ea = (exq[k].size() > 0) && (exq[k][0].ack_cyc == cyc);
                if (ea) h = exq[k][0];
                check("cpu_ack", k, 32'(ack[k][0]), 32'(ea && !h.port));
                check("iop_ack", k, 32'(ack[k][1]), 32'(ea && h.port));
                check("mem_start", k, 32'(mstart[k]), 32'(ea));
                if (ea) begin
                    void'(exq[k].pop_front());
                    cur[k]   = h;
                    cur_v[k] = 1'b1;
                end
                ed = 1'b0;
                if (cur_v[k]) begin
                    check("mem_we", k, 32'(mwe[k]), 32'(cur[k].we));
                    check("mem_addr", k, 32'(maddr[k]), 32'(cur[k].addr));
                    check("mem_wdata", k, mwdata[k], cur[k].wdata);
                    ed = (cur[k].done_cyc == cyc);
                end
                check("cpu_done", k, 32'(done[k][0]), 32'(ed && !cur[k].port));
                check("iop_done", k, 32'(done[k][1]), 32'(ed && cur[k].port));
                if (ed) begin
                    if (!cur[k].we) exp_rd[k][cur[k].port] = cur[k].rdata;
                    cur_v[k] = 1'b0;
                end
                check("cpu_rdata", k, rdata[k][0], exp_rd[k][0]);
                check("iop_rdata", k, rdata[k][1], exp_rd[k][1]);
                if (k == 0 && (ack[0][0] || ack[0][1])) begin
                    alog_c.push_back(cyc);
                    alog_p.push_back(int'(ack[0][1]));
                end
            end
        end
    end

    task automatic issue(int k, int p, bit w, logic [16:0] a, logic [31:0] d);
        int n = 0;
        req[k][p] = 1'b1; we[k][p] = w; addr[k][p] = a; wdata[k][p] = d;
        do begin @(posedge clk); #1; n++; end while (!ack[k][p] && n < 100);
        if (!ack[k][p]) check("issue_ack_timeout", k, 32'(ack[k][p]), 32'd1);
        req[k][p] = 1'b0;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #3 rst = 1'b1;
        @(posedge clk); #3 rst = 1'b0;
    endtask

    task automatic check_all_zero(string nm);
        for (int k = 0; k < 2; k++)
            check(nm, k, 32'((|ack[k]) | (|done[k]) | mstart[k] | mwe[k] | (|maddr[k]) |
                  (|mwdata[k]) | (|rdata[k])), 32'd0);
    endtask

    initial begin
        int c0;
        req = '0; we = '0; addr = '0; wdata = '0;
        #2 rst = 1'b1;
        #1 check_all_zero("async_reset_outputs");
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;

        // Single CPU read returning DEADBEEF on both instances.
        for (int k = 0; k < 2; k++) begin dir_v[k] = 1'b1; dir_d[k] = 32'hDEADBEEF; end
        fork
            issue(0, 0, 1'b0, 17'h00010, 32'h0);
            issue(1, 0, 1'b0, 17'h00010, 32'h0);
        join
        repeat (6) @(posedge clk);
        #1;
        check("directed_cpu_rdata", 0, rdata[0][0], 32'hDEADBEEF);
        check("directed_cpu_rdata", 1, rdata[1][0], 32'hDEADBEEF);

        // Both ports held high after reset: IOP, CPU, IOP, CPU, acks four cycles apart.
        pulse_reset();
        alog_c.delete(); alog_p.delete();
        c0 = cyc;
        req = '1; we = '0;
        repeat (20) @(posedge clk);
        #1 req = '0;
        check("alt_ack_count", 0, 32'(alog_c.size() >= 4), 32'd1);
        if (alog_c.size() >= 4)
            for (int i = 0; i < 4; i++) begin
                check("alt_ack_port", 0, 32'(alog_p[i]), 32'((i % 2 == 0) ? 1 : 0));
                check("alt_ack_cycle", 0, 32'(alog_c[i] - c0), 32'(1 + 4 * i));
            end
        repeat (6) @(posedge clk);

        // IOP write at the top of the address range.
        fork
            issue(0, 1, 1'b1, 17'h1FFFF, 32'h12345678);
            issue(1, 1, 1'b1, 17'h1FFFF, 32'h12345678);
        join
        repeat (6) @(posedge clk);

        // CPU requests while the IOP owns the memory.
        fork
            issue(0, 1, 1'b0, 17'h00100, 32'h0);
            begin @(posedge clk); #2 issue(0, 0, 1'b0, 17'h00200, 32'h0); end
        join
        repeat (6) @(posedge clk);

        // Reset one cycle after the ack abandons the read; then a fresh read completes.
        issue(0, 0, 1'b0, 17'h0AAAA, 32'h0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_all_zero("reset_mid_busy");
        @(posedge clk);
        #3 rst = 1'b0;
        fork
            issue(0, 0, 1'b0, 17'h00123, 32'h0);
            issue(1, 0, 1'b0, 17'h00123, 32'h0);
        join
        repeat (6) @(posedge clk);

        // Random traffic with occasional resets.
        for (int i = 0; i < 2500; i++) begin
            @(posedge clk); #1;
            for (int k = 0; k < 2; k++)
                for (int p = 0; p < 2; p++)
                    if (!req[k][p] || ack[k][p]) begin
                        if ($urandom_range(0, 99) < 45) begin
                            req[k][p]   = 1'b1;
                            we[k][p]    = 1'($urandom_range(0, 1));
                            wdata[k][p] = $urandom;
                            case ($urandom_range(0, 3))
                                0:       addr[k][p] = 17'h00000;
                                1:       addr[k][p] = 17'h1FFFF;
                                default: addr[k][p] = 17'($urandom);
                            endcase
                        end else req[k][p] = 1'b0;
                    end
            if ($urandom_range(0, 399) == 0) begin
                #2 rst = 1'b1;
                @(posedge clk);
                #3 rst = 1'b0;
            end
        end
        #1 req = '0;
        repeat (10) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++)
            check("drain_outstanding", k, 32'(exq[k].size()) + 32'(cur_v[k]), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
